ped_request_conditioner: RTL and testbench

PED_REQUEST_CONDITIONER -- requirements
Module: ped_request_conditioner

---
 rtl/ped_request_conditioner_pkg.sv | 28 ++
 rtl/ped_request_conditioner_sync_debounce.sv | 65 ++++++
 rtl/ped_request_conditioner.sv | 131 +++++++++++++
 tb/tb_ped_request_conditioner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ped_request_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ped_request_conditioner_pkg
//  Description : Shared FSM state encoding, default timing constants and
//                counter widths for the pedestrian request conditioner and
//                the traffic controller.
//  Revision    : 1.0  initial release
// ============================================================================
package ped_request_conditioner_pkg;

  // Pedestrian request FSM states. The fourth encoding (2'b11) is illegal
  // and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_REQUESTED = 2'b01,
    ST_HOLDOFF   = 2'b10
  } ped_state_e;

  // 20 ms debounce and 10 s lockout at a 50 MHz system clock.
  localparam int unsigned c_db_cycles_default      = 1000000;
  localparam int unsigned c_holdoff_cycles_default = 500000000;

  // Counter widths cover the full legal range of each timing parameter.
  localparam int unsigned c_db_cnt_w      = 24;
  localparam int unsigned c_holdoff_cnt_w = 29;

endpackage : ped_request_conditioner_pkg
`default_nettype wire

// File: rtl/ped_request_conditioner_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce
//  Description : Two-flop synchronizer followed by a debounce counter and a
//                stable-level register. The stable level follows the
//                synchronized input only after DB_CYCLES consecutive cycles
//                of disagreement; any single cycle of agreement restarts.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous, active-low reset
//                raw    - asynchronous, bouncing input
//                stable - debounced level
//  Revision    : 1.0  initial release
// ============================================================================
module sync_debounce
  import ped_request_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES = c_db_cycles_default
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [c_db_cnt_w-1:0] c_cnt_last = c_db_cnt_w'(DB_CYCLES - 1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  stable_q, stable_d;
  logic [c_db_cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      // cnt_q counts the disagreeing cycles already seen, so the cycle that
      // makes DB_CYCLES of them commits the new level.
      if (cnt_q == c_cnt_last) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : sync_debounce
`default_nettype wire

// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : ped_request_conditioner
//  Description : Conditions the raw pedestrian button and vehicle sensor,
//                latches a pedestrian request until the controller grants
//                it, then locks out new requests for HOLDOFF_CYCLES.
//  Ports       : clk        - system clock, rising edge
//                reset      - asynchronous, active-low reset
//                b1         - raw push-button (active-high, bouncing)
//                ir         - raw vehicle sensor (active-high, bouncing)
//                grant      - one-cycle pulse, pedestrian phase served
//                ped_req    - latched request level (REQUESTED state)
//                ir_present - debounced sensor level
//                b1_pulse   - one-cycle pulse on debounced b1 rise
//                req_count  - accepted requests, saturating at 255
//                lockout    - high while in HOLDOFF
//  Revision    : 1.0  initial release
// ============================================================================
module ped_request_conditioner
  import ped_request_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = c_db_cycles_default,
  parameter int unsigned HOLDOFF_CYCLES = c_holdoff_cycles_default
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       b1,
  input  logic       ir,
  input  logic       grant,
  output logic       ped_req,
  output logic       ir_present,
  output logic       b1_pulse,
  output logic [7:0] req_count,
  output logic       lockout
);

  localparam logic [c_holdoff_cnt_w-1:0] c_holdoff_load =
    c_holdoff_cnt_w'(HOLDOFF_CYCLES - 1);

  logic                       b1_stable;
  logic                       ir_stable;
  logic                       b1_prev_q, b1_prev_d;
  logic                       b1_pulse_q, b1_pulse_d;
  ped_state_e                 state_q, state_d;
  logic [c_holdoff_cnt_w-1:0] holdoff_q, holdoff_d;
  logic [7:0]                 req_count_q, req_count_d;

  sync_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_b1_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (b1),
    .stable (b1_stable)
  );

  sync_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_ir_db (
    .clk    (clk),
    .reset  (reset),
    .raw    (ir),
    .stable (ir_stable)
  );

  // Registered rising-edge detect: the pulse lands the cycle after the
  // stable level rises, so the FSM only ever sees a flop output.
  always_comb begin
    b1_prev_d  = b1_stable;
    b1_pulse_d = b1_stable & ~b1_prev_q;
  end

  always_comb begin
    state_d     = state_q;
    holdoff_d   = holdoff_q;
    req_count_d = req_count_q;
    case (state_q)
      ST_IDLE: begin
        // A coincident grant is irrelevant here; only the press matters.
        if (b1_pulse_q) begin
          state_d = ST_REQUESTED;
          if (req_count_q != 8'hFF) begin
            req_count_d = req_count_q + 1'b1;
          end
        end
      end
      ST_REQUESTED: begin
        if (grant) begin
          state_d   = ST_HOLDOFF;
          holdoff_d = c_holdoff_load;
        end
      end
      ST_HOLDOFF: begin
        // Loaded with N-1 so the state lasts exactly HOLDOFF_CYCLES cycles.
        if (holdoff_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          holdoff_d = holdoff_q - 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        holdoff_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b1_prev_q   <= 1'b0;
      b1_pulse_q  <= 1'b0;
      state_q     <= ST_IDLE;
      holdoff_q   <= '0;
      req_count_q <= '0;
    end else begin
      b1_prev_q   <= b1_prev_d;
      b1_pulse_q  <= b1_pulse_d;
      state_q     <= state_d;
      holdoff_q   <= holdoff_d;
      req_count_q <= req_count_d;
    end
  end

  assign ped_req    = (state_q == ST_REQUESTED);
  assign lockout    = (state_q == ST_HOLDOFF);
  assign ir_present = ir_stable;
  assign b1_pulse   = b1_pulse_q;
  assign req_count  = req_count_q;

endmodule : ped_request_conditioner
`default_nettype wire

// File: tb/tb_ped_request_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ped_request_conditioner
//  Description : Self-checking bench for ped_request_conditioner with a
//                window-based reference model and directed scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ped_request_conditioner;

  localparam int DB = 4;
  localparam int HO = 8;

  logic       clk;
  logic       reset;
  logic       b1;
  logic       ir;
  logic       grant;
  logic       ped_req;
  logic       ir_present;
  logic       b1_pulse;
  logic [7:0] req_count;
  logic       lockout;

  ped_request_conditioner #(
    .DB_CYCLES      (DB),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .b1         (b1),
    .ir         (ir),
    .grant      (grant),
    .ped_req    (ped_req),
    .ir_present (ir_present),
    .b1_pulse   (b1_pulse),
    .req_count  (req_count),
    .lockout    (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model. Raw inputs sampled at each edge form a history; the
  // synchronized value seen at edge n is the raw sample of edge n-2, so a
  // level is accepted once the samples of edges n-2 .. n-(DB+1) all
  // disagree with the current stable level.
  // ---------------------------------------------------------------------
  logic [DB+1:0] m_b1_h, m_ir_h;
  logic [DB+1:0] nh_b1, nh_ir;
  logic          m_b1_st, m_ir_st, m_rose, m_pulse;
  logic          flip_b1, flip_ir;
  int            m_state;      // 0 idle, 1 requested, 2 holdoff
  int            m_grant_cyc;
  int            m_count;

  assign nh_b1   = {m_b1_h[DB:0], b1};
  assign nh_ir   = {m_ir_h[DB:0], ir};
  assign flip_b1 = (nh_b1[DB+1:2] == {DB{~m_b1_st}});
  assign flip_ir = (nh_ir[DB+1:2] == {DB{~m_ir_st}});

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_b1_h      <= '0;
      m_ir_h      <= '0;
      m_b1_st     <= 1'b0;
      m_ir_st     <= 1'b0;
      m_rose      <= 1'b0;
      m_pulse     <= 1'b0;
      m_state     <= 0;
      m_grant_cyc <= 0;
      m_count     <= 0;
    end else begin
      m_b1_h  <= nh_b1;
      m_ir_h  <= nh_ir;
      if (flip_b1) m_b1_st <= ~m_b1_st;
      if (flip_ir) m_ir_st <= ~m_ir_st;
      m_rose  <= flip_b1 && !m_b1_st;
      m_pulse <= m_rose;
      case (m_state)
        0: if (m_pulse) begin
             m_state <= 1;
             if (m_count < 255) m_count <= m_count + 1;
           end
        1: if (grant) begin
             m_state     <= 2;
             m_grant_cyc <= cyc;
           end
        default: if (cyc - m_grant_cyc >= HO) m_state <= 0;
      endcase
    end
  end

  // Per-cycle comparison plus observation counters for literal checks.
  int pulse_cnt  = 0;
  int pulse_cyc  = -1;
  int ir_hi_cnt  = 0;
  int ir_first   = -1;
  int lock_cnt   = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ped_req",    ped_req,    (m_state == 1));
      check("lockout",    lockout,    (m_state == 2));
      check("ir_present", ir_present, m_ir_st);
      check("b1_pulse",   b1_pulse,   m_pulse);
      check("req_count",  req_count,  m_count);
      if (b1_pulse === 1'b1) begin
        pulse_cnt++;
        pulse_cyc = cyc;
      end
      if (ir_present === 1'b1) begin
        ir_hi_cnt++;
        if (ir_first < 0) ir_first = cyc;
      end
      if (lockout === 1'b1) lock_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic grant_pulse();
    grant = 1'b1;
    tick(1);
    grant = 1'b0;
  endtask

  int e0;
  int snap;

  initial begin
    reset = 1'b0;
    b1    = 1'b0;
    ir    = 1'b0;
    grant = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("reset_outputs", {ped_req, ir_present, b1_pulse, lockout, req_count}, 0);
    reset = 1'b1;
    tick(3);

    // Bouncing button, then a clean hold: one pulse 7 cycles after the rise.
    for (int i = 0; i < 5; i++) begin
      b1 = 1'b1; tick(2);
      b1 = 1'b0; tick(2);
    end
    b1 = 1'b1;
    e0 = cyc;
    tick(12);
    check("bounce_one_pulse", pulse_cnt, 1);
    check("pulse_latency", pulse_cyc - e0, 7);
    check("ped_req_set", ped_req, 1);
    check("count_after_first", req_count, 1);

    // Short sensor glitch is rejected; a long one is accepted after 6.
    ir = 1'b1; tick(3);
    ir = 1'b0; tick(10);
    check("ir_glitch_rejected", ir_hi_cnt, 0);
    ir = 1'b1;
    e0 = cyc;
    tick(12);
    check("ir_latency", ir_first - e0, 6);
    ir = 1'b0;
    tick(8);

    // Grant, lockout length and a press swallowed by the lockout.
    b1 = 1'b0; tick(8);
    lock_cnt = 0;
    snap = pulse_cnt;
    grant_pulse();
    check("ped_req_cleared", ped_req, 0);
    check("lockout_set", lockout, 1);
    b1 = 1'b1; tick(8);
    b1 = 1'b0; tick(10);
    check("lockout_cycles", lock_cnt, 8);
    check("press_during_lockout_pulsed", pulse_cnt - snap, 1);
    check("no_req_during_lockout", ped_req, 0);
    check("count_unchanged", req_count, 1);
    b1 = 1'b1; tick(10);
    check("req_after_lockout", ped_req, 1);
    check("count_second", req_count, 2);
    b1 = 1'b0; tick(8);
    grant_pulse();
    tick(12);

    // Grant alone in idle does nothing.
    grant_pulse();
    tick(3);
    check("idle_grant_lockout", lockout, 0);
    check("idle_grant_ped_req", ped_req, 0);

    // Press pulse coincident with grant in idle still requests.
    b1 = 1'b1;
    e0 = cyc;
    tick(7);
    check("coincident_pulse_now", b1_pulse, 1);
    grant_pulse();
    check("coincident_requested", ped_req, 1);
    check("count_third", req_count, 3);

    // 300 more accepted requests saturate the counter.
    for (int i = 0; i < 300; i++) begin
      grant_pulse();
      b1 = 1'b0; tick(6);
      b1 = 1'b1; tick(12);
    end
    check("count_saturated", req_count, 255);
    check("ped_req_after_loop", ped_req, 1);

    // Asynchronous reset in the middle of the hold-off count.
    b1 = 1'b0; tick(8);
    grant_pulse();
    tick(4);
    check("holdoff_before_reset", lockout, 1);
    snap = pulse_cnt;
    reset = 1'b0;
    #1;
    check("async_reset_outputs", {ped_req, ir_present, b1_pulse, lockout, req_count}, 0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    tick(15);
    check("no_pulse_after_reset", pulse_cnt - snap, 0);
    check("count_after_reset", req_count, 0);
    check("idle_after_reset", {ped_req, lockout}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ped_request_conditioner
`default_nettype wire
